// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of a requester index for n requesters (n >= 2).
    function automatic int req_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic                          fifo_full;

    // Producers and the FIFO side.
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wdata
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin search starting after last_owner
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest requester after last_owner wins.
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(last_owner) + i) % NUM_REQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a FIFO write port; optional stats via FIFO_ARB_STATS_EN
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fifo_wr_arbiter_if.slave       bus,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt_o
`endif
);

    localparam int IDX_W = req_idx_w(NUM_REQ);
    localparam int BCW   = $clog2(BURST_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_valid;
    logic             xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State, owner, beat counter and round-robin pointer; reset drops any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state logic and port outputs; a write happens only in BURST when the owner is valid and the FIFO has room.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;

        owner_valid = bus.req_valid[owner_q];
        xfer        = (state_q == BURST) && owner_valid && !bus.fifo_full;

        bus.fifo_wr_en = xfer;
        bus.fifo_wdata = xfer ? bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        bus.req_ready  = xfer ? (NUM_REQ'(1) << owner_q) : '0;
        grant_o        = (state_q == BURST) ? (NUM_REQ'(1) << owner_q) : '0;
        busy_o         = (state_q == BURST);

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (!owner_valid) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (bus.req_last[owner_q] || beat_cnt_q == BCW'(BURST_MAX - 1)) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Per-requester saturating beat counters, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (xfer && owner_q == IDX_W'(k) && cnt_q[k] != {CNT_WIDTH{1'b1}})
                    cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
        assign grant_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
`ifdef FIFO_ARB_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0] grant;
    logic          busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*CW-1:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_MAX  (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Slot 0=0x10, 1=0x20, 2=0xA5, 3=0x40
    localparam logic [NR*DW-1:0] DATA = 32'h40A52010;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] grant;
        logic       wr;
        logic [7:0] wdata;
        logic [3:0] ready;
        logic       busy;
    } vec_t;

    vec_t vt [15];

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (bus.fifo_wr_en && bus.fifo_full) begin
                bad++;
                $display("FAIL overflow: wr_en=1 while full at %0t", $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0]  exp_d;
        logic [3:0]  exp_g;
        logic [7:0]  data_b [4];

        data_b[0] = 8'h10; data_b[1] = 8'h20; data_b[2] = 8'hA5; data_b[3] = 8'h40;

        //             valid    last     full  grant    wr    wdata  ready    busy
        vt[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vt[1]  = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vt[2]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0100, 1'b1};
        vt[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vt[4]  = '{4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vt[5]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1};
        vt[6]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1};
        vt[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b1};
        vt[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vt[9]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b1};
        vt[10] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b1};
        vt[11] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b1};
        vt[12] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h20, 4'b0010, 1'b1};
        vt[13] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h20, 4'b0010, 1'b1};
        vt[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = DATA;
        bus.fifo_full = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_wdata", 32'(bus.fifo_wdata), 32'h0);
        rst_n = 1'b1;

        // Table: single-beat grant, abandoned burst + RR, full stall, last-terminated burst.
        for (int i = 0; i < 15; i++) begin
            bus.req_valid = vt[i].valid;
            bus.req_last  = vt[i].last;
            bus.fifo_full = vt[i].full;
            @(negedge clk);
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].grant));
            check($sformatf("v%0d_wr", i), 32'(bus.fifo_wr_en), 32'(vt[i].wr));
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vt[i].ready));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            if (vt[i].wr)
                check($sformatf("v%0d_wdata", i), 32'(bus.fifo_wdata), 32'(vt[i].wdata));
            @(posedge clk);
            #1;
        end

        // Async reset mid-burst: requester 3 is next in RR order after owner 1.
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_grant", 32'(grant), 32'h8);
        check("pre_rst_wr", 32'(bus.fifo_wr_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_wr", 32'(bus.fifo_wr_en), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_ready", 32'(bus.req_ready), 32'h0);
        check("async_rst_wdata", 32'(bus.fifo_wdata), 32'h0);
        bus.req_valid = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters busy: 4 beats per grant, one idle bubble, order 0,1,2,3,0.
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c % 5 == 4) begin
                check($sformatf("rr_c%0d_grant", c), 32'(grant), 32'h0);
                check($sformatf("rr_c%0d_wr", c), 32'(bus.fifo_wr_en), 32'h0);
            end else begin
                exp_g = 4'(1) << ((c / 5) % 4);
                exp_d = data_b[(c / 5) % 4];
                check($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(exp_g));
                check($sformatf("rr_c%0d_wr", c), 32'(bus.fifo_wr_en), 32'h1);
                check($sformatf("rr_c%0d_wdata", c), 32'(bus.fifo_wdata), 32'(exp_d));
            end
        end

`ifdef FIFO_ARB_STATS_EN
        // Requester 3 writes 20 beats; 4-bit counter saturates at 15.
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("stats_reset", 32'(grant_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("stats_cnt3", 32'(grant_cnt[3*CW +: CW]), 32'd15);
        check("stats_cnt0", 32'(grant_cnt[0*CW +: CW]), 32'd0);
        check("stats_cnt1", 32'(grant_cnt[1*CW +: CW]), 32'd0);
        check("stats_cnt2", 32'(grant_cnt[2*CW +: CW]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
